// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: self-timed column scan engine for a multiplexed LED
// matrix. A shadow copy of the cell bitmap is taken on IDLE exit and at every
// frame wrap. Each column is preceded by a blanking interval and then driven
// for a fixed dwell time.
// Optional feature macro: LED_SCAN_BRIGHTNESS_EN adds a brightness input that
// limits how many cycles of each column's dwell actually light the LEDs.
module led_matrix_scanner #(
  parameter int ROWS          = 5,
  parameter int COLS          = 5,
  parameter int TICKS_PER_COL = 1000,
  parameter int BLANK_TICKS   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic [ROWS*COLS-1:0]             cells,
`ifdef LED_SCAN_BRIGHTNESS_EN
  input  logic [$clog2(TICKS_PER_COL+1)-1:0] brightness,
`endif
  output logic [ROWS-1:0]                  rows,
  output logic [COLS-1:0]                  cols,
  output logic [$clog2(COLS):0]            col_index,
  output logic                             frame_done
);

  localparam int TICK_MAX = (TICKS_PER_COL > BLANK_TICKS) ? TICKS_PER_COL : BLANK_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam int COL_W    = $clog2(COLS) + 1;

  // Reject parameter values the scan timing cannot represent.
  if (ROWS < 1 || ROWS > 16) begin : g_bad_rows
    $error("led_matrix_scanner: ROWS must be 1..16");
  end
  if (COLS < 1 || COLS > 16) begin : g_bad_cols
    $error("led_matrix_scanner: COLS must be 1..16");
  end
  if (TICKS_PER_COL < 1) begin : g_bad_ticks
    $error("led_matrix_scanner: TICKS_PER_COL must be >= 1");
  end
  if (BLANK_TICKS < 1) begin : g_bad_blank
    $error("led_matrix_scanner: BLANK_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROWS*COLS-1:0]   shadow_q, shadow_d;

  logic blank_last;
  logic drive_last;
  logic col_last;
  logic lit;

  assign blank_last = (tick_q == TICK_W'(BLANK_TICKS - 1));
  assign drive_last = (tick_q == TICK_W'(TICKS_PER_COL - 1));
  assign col_last   = (col_q == COL_W'(COLS - 1));

  // State register: FSM, tick counter, column counter and shadow frame.
  // NOTE: the shadow frame is reset too, so the matrix shows a defined (dark)
  // image; it is small enough that reset cost is irrelevant next to safety.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      col_q    <= '0;
      shadow_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state_q  <= state_d;
      tick_q   <= tick_d;
      col_q    <= col_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state logic: blank/drive sequencing, column advance, frame wrap.
  always_comb begin
    // NOTE: hold-by-default assignments first, so no path infers a latch.
    state_d  = state_q;
    tick_d   = tick_q;
    col_d    = col_q;
    shadow_d = shadow_q;

    if (!ena) begin
      // Disable wins over everything, including a coincident frame wrap.
      state_d = IDLE;
      tick_d  = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          shadow_d = cells;
          col_d    = '0;
          tick_d   = '0;
          state_d  = BLANK;
        end
        BLANK: begin
          if (blank_last) begin
            tick_d  = '0;
            state_d = DRIVE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        DRIVE: begin
          if (drive_last) begin
            tick_d  = '0;
            state_d = BLANK;
            if (col_last) begin
              col_d    = '0;
              shadow_d = cells;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
          col_d   = '0;
        end
      endcase
    end
  end

  // Lit qualifier: only DRIVE lights LEDs, optionally gated by brightness.
  always_comb begin
`ifdef LED_SCAN_BRIGHTNESS_EN
    lit = (state_q == DRIVE) && (32'(tick_q) < 32'(brightness));
`else
    lit = (state_q == DRIVE);
`endif
  end

  // Output decode: one-hot column source and active-low row sinks.
  always_comb begin
    rows = '1;
    cols = '0;
    for (int c = 0; c < COLS; c++) begin
      if (lit && (col_q == COL_W'(c))) begin
        cols[c] = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
          rows[r] = ~shadow_q[r*COLS + c];
        end
      end
    end
  end

  assign col_index  = col_q;
  // Decoded from the current DRIVE state, so it pulses even if ena falls now.
  assign frame_done = (state_q == DRIVE) && drive_last && col_last;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner. The reference model tracks the
// position inside a frame as a plain cycle count and derives column, blank
// and drive phases by division; expected outputs go into a queue that a
// separate negedge monitor pops and compares.
module tb_led_matrix_scanner;

  localparam int ROWS  = 3;
  localparam int COLS  = 4;
  localparam int TPC   = 4;
  localparam int BLANK = 1;
  localparam int N     = ROWS * COLS;
  localparam int CW    = $clog2(COLS) + 1;
  localparam int BW    = $clog2(TPC + 1);
  localparam int PER   = BLANK + TPC;
  localparam int FRAME = COLS * PER;

  logic            clk;
  logic            rst_n;
  logic            ena;
  logic [N-1:0]    cells;
  logic [BW-1:0]   brightness;
  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;
  logic [CW-1:0]   col_index;
  logic            frame_done;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .TICKS_PER_COL(TPC), .BLANK_TICKS(BLANK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .cells(cells),
`ifdef LED_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .rows(rows),
    .cols(cols),
    .col_index(col_index),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS-1:0] rows;
    logic [COLS-1:0] cols;
    logic [CW-1:0]   idx;
    logic            fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  bit           m_run = 1'b0;
  int           m_pos = 0;
  logic [N-1:0] m_frame = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  function automatic exp_t expected();
    exp_t e;
    int   col, ph;
    bit   lit;
    e.rows = '1;
    e.cols = '0;
    e.idx  = '0;
    e.fd   = 1'b0;
    if (m_run) begin
      col = m_pos / PER;
      ph  = m_pos % PER;
      lit = (ph >= BLANK);
`ifdef LED_SCAN_BRIGHTNESS_EN
      lit = lit && ((ph - BLANK) < int'(brightness));
`endif
      e.idx = CW'(col);
      e.fd  = (m_pos == FRAME - 1);
      if (lit) begin
        e.cols = COLS'(1) << col;
        for (int r = 0; r < ROWS; r++) e.rows[r] = ~m_frame[r*COLS + col];
      end
    end
    return e;
  endfunction

  // One clock: advance the model with what the DUT sampled, apply new inputs
  // (an asserted reset acts at once), then queue the expected outputs.
  task automatic step(input logic e, input logic [N-1:0] c, input logic r, input logic [BW-1:0] b);
    @(posedge clk);
    #1;
    if (!rst_n || !ena) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run   = 1'b1;
      m_pos   = 0;
      m_frame = cells;
    end else if (m_pos == FRAME - 1) begin
      m_pos   = 0;
      m_frame = cells;
    end else begin
      m_pos++;
    end
    ena        = e;
    cells      = c;
    rst_n      = r;
    brightness = b;
    if (!r) m_run = 1'b0;
    exp_q.push_back(expected());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(ena, cells, rst_n, brightness);
  endtask

  // Advance until the model reaches column col in its drive phase.
  task automatic run_to_drive(input int col, input string name);
    int i;
    for (i = 0; i < 4 * FRAME; i++) begin
      if (m_run && (m_pos / PER == col) && (m_pos % PER >= BLANK)) break;
      step(ena, cells, rst_n, brightness);
    end
    check(name, 32'(i < 4 * FRAME), 32'd1);
  endtask

  // Monitor: pops one expectation per cycle and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rows", 32'(rows), 32'(e.rows));
        check("cols", 32'(cols), 32'(e.cols));
        check("col_index", 32'(col_index), 32'(e.idx));
        check("frame_done", 32'(frame_done), 32'(e.fd));
      end
    end
  end

  // Stimulus.
  initial begin
    logic [N-1:0] rc;
    rst_n      = 1'b0;
    ena        = 1'b1;
    cells      = N'(1) << 6;
    brightness = BW'(TPC);

    // Reset held with ena high: outputs stay at reset values.
    run(4);

    // Single cell at (1,2): three frames.
    step(1'b1, N'(1) << 6, 1'b1, brightness);
    run(3 * FRAME);

    // Tear-free: change cells during column 1; old frame finishes first.
    run_to_drive(1, "reach_col1");
    step(1'b1, N'(1), 1'b1, brightness);
    run(2 * FRAME);

    // Disable during column 2 drive, then restart.
    run_to_drive(2, "reach_col2");
    step(1'b0, cells, 1'b1, brightness);
    run(3);
    step(1'b1, N'(1) << 6, 1'b1, brightness);
    run(FRAME + 5);

    // Asynchronous reset between edges during a drive cycle.
    run_to_drive(2, "reach_col2_rst");
    step(1'b1, cells, 1'b0, brightness);
    #2;
    check("async_cols", 32'(cols), 32'd0);
    check("async_rows", 32'(rows), 32'h7);
    run(2);
    step(1'b1, cells, 1'b1, brightness);
    run(FRAME + 5);

`ifdef LED_SCAN_BRIGHTNESS_EN
    step(1'b1, N'(12'hfff), 1'b1, BW'(2));
    run(FRAME + 3);
    step(1'b1, cells, 1'b1, BW'(0));
    run(FRAME + 3);
    step(1'b1, cells, 1'b1, BW'(7));
    run(FRAME + 3);
`endif

    // Randomised traffic: cell changes, occasional disables, brightness.
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 7) == 0) ? N'($urandom) : cells;
      step(($urandom_range(0, 29) != 0), rc, 1'b1, BW'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Self-timed, parametrised scan engine for a multiplexed LED matrix with independent row and column counts. It latches a cell bitmap into a shadow frame buffer at every frame boundary and walks the columns with a programmable dwell time. A blanking interval precedes each column to suppress ghosting. It sits between the game-of-life cell array and the physical LED pins, replacing externally sequenced column selection with an internal counter/FSM and a frame-complete strobe.

## Interface
- ROWS, default 5: number of LED rows (1..16).
- COLS, default 5: number of LED columns (1..16); need not equal ROWS.
- TICKS_PER_COL, default 1000: clock cycles a column is driven per visit (≥1).
- BLANK_TICKS, default 2: clock cycles all LEDs are off before each column (≥1).
- Out-of-range parameters raise `$error` at elaboration.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  scan enable; low forces IDLE.
- cells  input  ROWS*COLS  bitmap; cell (r,c) is bit r*COLS+c; 1 = lit.
- rows  output  ROWS  row sinks, active-low; rows[r]=0 lights row r in the selected column.
- cols  output  COLS  column sources, one-hot active-high, or all zero.
- col_index  output  $clog2(COLS)+1  column currently scanned.
- frame_done  output  1  one-cycle pulse when the last column's drive ends.

## Operation
- State: FSM {IDLE, BLANK, DRIVE}, tick counter (width for max(TICKS_PER_COL, BLANK_TICKS)), column counter, ROWS*COLS shadow register.
- Outputs are a pure decode of registered state:
  - DRIVE: cols = one-hot(col_index); rows[r] = ~shadow[r*COLS+col_index].
  - IDLE and BLANK: cols = 0, rows = all ones.
- Reset values: IDLE, tick=0, col_index=0, shadow=0, rows=all 1, cols=0, frame_done=0.
- IDLE:
  - If ena=1: shadow<=cells, col_index<=0, tick<=0, go to BLANK.
  - Otherwise stay in IDLE.
- BLANK: count BLANK_TICKS cycles (tick 0..BLANK_TICKS-1). On the last one: tick<=0, go to DRIVE.
- DRIVE: count TICKS_PER_COL cycles. On the last one:
  - If col_index<COLS-1: col_index+1, go to BLANK.
  - If col_index==COLS-1: col_index<=0, shadow<=cells, frame_done=1 for that cycle, go to BLANK.
- ena=0 in any state: next edge goes to IDLE with tick=0, col_index=0. The frame is abandoned and frame_done is not asserted. Shadow is retained but reloaded on re-entry.
- cells is sampled only on IDLE exit and at frame wrap. Mid-frame changes never tear the displayed frame.
- At most one column is ever enabled. Column changes always pass through a BLANK cycle with cols=0.

## Timing
- Frame period: COLS*(BLANK_TICKS+TICKS_PER_COL) cycles.
- Start-up latency:
  - ena rising in IDLE: BLANK begins on the next edge.
  - First lit cycle is 1+BLANK_TICKS edges after ena is sampled high.
- frame_done:
  - Asserted in the cycle that is the final DRIVE cycle of column COLS-1 (combinational from state/tick/col_index; glitch-free by decode of registers).
  - The cycle after it is BLANK for column 0 with the new shadow.
- rst_n low: all outputs take reset values immediately, without a clock edge. Release is synchronous to the next clk edge.
- Simultaneous ena fall and frame wrap: ena wins; IDLE, no shadow load. frame_done still pulses because it is a decode of the current DRIVE state.

## Configuration
- LED_SCAN_BRIGHTNESS_EN defined:
  - Adds input `brightness` [$clog2(TICKS_PER_COL+1)-1:0].
  - In DRIVE, cols/rows are active only while tick < brightness; otherwise off as in BLANK.
  - brightness ≥ TICKS_PER_COL gives full dwell. 0 gives a dark display with timing and frame_done unchanged.
  - brightness is sampled every cycle.
- Undefined: port absent; full dwell always.

## Test plan
Bench parameters: ROWS=3, COLS=4, TICKS_PER_COL=4, BLANK_TICKS=1.
- Reset: hold rst_n=0 with ena=1 -> rows=3'b111, cols=4'b0000, col_index=0, frame_done=0 throughout.
- Single cell: cells bit 6 (r=1,c=2), ena=1 -> frame_done every 20 cycles; cols=4'b0100 for 4 cycles with rows=3'b101; all other drive cycles rows=3'b111; one BLANK cycle with cols=0 before each column.
- Tear-free: change cells to bit 0 while col_index=1 -> current frame still shows bit 6; bit 0 (cols=4'b0001, rows=3'b110) appears only after frame_done.
- Disable mid-frame: drop ena during col 2 DRIVE -> next edge rows=111, cols=0, col_index=0, no frame_done; re-raise ena -> restart at col 0 after 1 BLANK cycle.
- Async reset mid-DRIVE: assert rst_n=0 between edges -> cols=0, rows=111 before the next edge; recovery as in the disable case.
- With LED_SCAN_BRIGHTNESS_EN: brightness=2 -> each column lit 2 of 4 DRIVE cycles; brightness=0 -> never lit, frame_done period still 20; brightness=7 -> full 4-cycle dwell.
